// File: rtl/instr_encoder.sv
// Packs field-level RV32I micro-op requests into instruction words and streams
// them sequentially into instruction memory, flagging illegal immediates/fields.
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-2:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-2:0] err_idx,
    output logic                  ovf
);

    localparam int unsigned CW  = ADDR_WIDTH - 1;
    localparam int unsigned IW  = ADDR_WIDTH - 2;
    localparam int unsigned CAP = 1 << IW;

    localparam logic [CW-1:0] CAP_LAST = CW'(CAP - 1);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IALU   = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;

    logic signed [31:0] simm;
    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               imm12_ok;
    logic               is_shift;
    logic [CW-1:0]      nidx;
    logic               accept;

    assign simm = $signed(in_imm);

    // Index the next accepted word lands on: a pending write still owns `count`.
    assign nidx     = count + CW'(mem_we);
    assign in_ready = (state == S_LOAD) && !((count == CAP_LAST) && mem_we);
    assign accept   = in_valid && in_ready;

    assign imm12_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // Field packing and legality for each request kind.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (in_kind)
            4'd0: begin
                enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
                enc_legal = (in_funct7 == F7_ZERO) ||
                            ((in_funct7 == F7_ALT) &&
                             ((in_funct3 == 3'b000) || (in_funct3 == 3'b101)));
            end
            4'd1: begin
                if (is_shift) begin
                    enc_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IALU};
                    enc_legal = (in_imm[31:5] == 27'd0) &&
                                ((in_funct7 == F7_ZERO) ||
                                 ((in_funct7 == F7_ALT) && (in_funct3 == 3'b101)));
                end else begin
                    enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
                    enc_legal = imm12_ok;
                end
            end
            4'd2: begin
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
                enc_legal = imm12_ok;
            end
            4'd3: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
                enc_legal = imm12_ok;
            end
            4'd4: begin
                enc_word  = {in_imm[31:12], in_rd, OP_LUI};
                enc_legal = (in_imm[11:0] == 12'd0);
            end
            4'd5: begin
                enc_word  = {in_imm[31:12], in_rd, OP_AUIPC};
                enc_legal = (in_imm[11:0] == 12'd0);
            end
            4'd6: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                enc_legal = !in_imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
            end
            4'd7: begin
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
                enc_legal = imm12_ok;
            end
            4'd8: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OP_BRANCH};
                enc_legal = !in_imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094) &&
                            (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Control FSM with registered write port and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
            ovf       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                count <= count + CW'(1);
            end
            if (start) begin
                // Restart from any state; a pending word is dropped.
                state   <= S_LOAD;
                busy    <= 1'b1;
                done    <= 1'b0;
                count   <= '0;
                err     <= 1'b0;
                err_idx <= '0;
                ovf     <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (accept) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {nidx[IW-1:0], 2'b00};
                            mem_wdata <= enc_legal ? enc_word : NOP_WORD;
                            if (!enc_legal) begin
                                err <= 1'b1;
                                if (!err) begin
                                    err_idx <= nidx;
                                end
                            end
                            if (in_last || (nidx == CAP_LAST)) begin
                                state <= S_FLUSH;
                                if (!in_last) begin
                                    ovf <= 1'b1;
                                end
                            end
                        end
                    end
                    S_FLUSH: begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 1024-byte instance for encoding/error
// behaviour and a 16-byte instance for the capacity-overflow path.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready_a, mem_we_a, busy_a, done_a, err_a, ovf_a;
    logic [9:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  count_a, err_idx_a;

    logic        in_ready_b, mem_we_b, busy_b, done_b, err_b, ovf_b;
    logic [3:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  count_b, err_idx_b;

    typedef struct {
        int          addr;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   en_a = 1'b0;
    bit   en_b = 1'b0;

    localparam logic [31:0] NOP = 32'h00000013;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder #(.ADDR_WIDTH(10), .NOP_WORD(NOP)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .count(count_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_idx(err_idx_a), .ovf(ovf_a)
    );

    instr_encoder #(.ADDR_WIDTH(4), .NOP_WORD(NOP)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .count(count_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_idx(err_idx_b), .ovf(ovf_b)
    );

    // Write monitors: each observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (en_a && mem_we_a === 1'b1) begin
            exp_t e;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL write_a unexpected: addr=%h data=%h", mem_addr_a, mem_wdata_a);
            end else begin
                e = qa.pop_front();
                if (mem_addr_a !== 10'(e.addr) || mem_wdata_a !== e.word || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write_a: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             mem_addr_a, mem_wdata_a, cyc, 10'(e.addr), e.word, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en_b && mem_we_b === 1'b1) begin
            exp_t e;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL write_b unexpected: addr=%h data=%h", mem_addr_b, mem_wdata_b);
            end else begin
                e = qb.pop_front();
                if (mem_addr_b !== 4'(e.addr) || mem_wdata_b !== e.word || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write_b: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             mem_addr_b, mem_wdata_b, cyc, 4'(e.addr), e.word, e.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one request and queue its expected write once the handshake is seen.
    task automatic send(input bit sel, input logic [3:0] k, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                        input logic [31:0] w, input int idx);
        bit ok = 1'b0;
        int n = 0;
        exp_t e;
        in_kind = k; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            @(negedge clk);
            if ((sel ? in_ready_b : in_ready_a) === 1'b1) begin
                e.addr = idx * 4; e.word = w; e.cyc = cyc + 1;
                if (sel) qb.push_back(e); else qa.push_back(e);
                last_acc = cyc + 1;
                ok = 1'b1;
            end
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed low, want accept of idx %0d", idx);
        end
    endtask

    // Wait for all queued writes, then one more edge so FLUSH has settled.
    task automatic drain(input bit sel);
        int n = 0;
        while ((sel ? qb.size() : qa.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if ((sel ? qb.size() : qa.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes outstanding, want 0", sel ? qb.size() : qa.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, count_a, busy_a, done_a, err_a, err_idx_a, ovf_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: we=%b addr=%h data=%h count=%0d busy=%b done=%b err=%b idx=%0d ovf=%b rdy=%b, want all 0",
                     mem_we_a, mem_addr_a, mem_wdata_a, count_a, busy_a, done_a, err_a, err_idx_a, ovf_a, in_ready_a);
        end
        checks++;
        if ({in_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, count_b, busy_b, done_b, err_b, err_idx_b, ovf_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs not all 0 (we=%b count=%0d busy=%b done=%b)", mem_we_b, count_b, busy_b, done_b);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b, want 0 0", in_ready_a, busy_a);
        end
        en_a = 1'b1;
    endtask

    task automatic test_addi();
        pulse_start();
        checks++;
        if (busy_a !== 1'b1 || in_ready_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL start_load: busy=%b in_ready=%b done=%b, want 1 1 0", busy_a, in_ready_a, done_a);
        end
        send(0, 4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 0);
        drain(0);
        checks++;
        if (count_a !== 9'd1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL addi_status: count=%0d busy=%b done=%b, want 1 1 0", count_a, busy_a, done_a);
        end
    endtask

    task automatic test_r_shift();
        pulse_start();
        send(0, 4'd0, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h402081B3, 0);
        send(0, 4'd1, 3'd5, 7'h20, 5'd5, 5'd5, 5'd0, 32'd3, 1'b1, 32'h4032D293, 1);
        drain(0);
        checks++;
        if (done_a !== 1'b1 || count_a !== 9'd2 || busy_a !== 1'b0 || err_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL r_shift_done: done=%b count=%0d busy=%b err=%b ovf=%b, want 1 2 0 0 0",
                     done_a, count_a, busy_a, err_a, ovf_a);
        end
    endtask

    task automatic test_branch_jal();
        pulse_start();
        checks++;
        if (done_a !== 1'b0 || count_a !== 9'd0) begin
            errors++;
            $display("FAIL restart_clear: done=%b count=%0d, want 0 0", done_a, count_a);
        end
        send(0, 4'd8, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, 32'hFE208CE3, 0);
        send(0, 4'd6, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF, 1);
        drain(0);
        checks++;
        if (done_a !== 1'b1 || count_a !== 9'd2) begin
            errors++;
            $display("FAIL branch_jal_done: done=%b count=%0d, want 1 2", done_a, count_a);
        end
    endtask

    task automatic test_illegal();
        pulse_start();
        for (int i = 0; i < 3; i++)
            send(0, 4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, i);
        send(0, 4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, NOP, 3);
        send(0, 4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 4);
        send(0, 4'd4, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b1, NOP, 5);
        drain(0);
        checks++;
        if (err_a !== 1'b1 || err_idx_a !== 9'd3 || done_a !== 1'b1 || count_a !== 9'd6) begin
            errors++;
            $display("FAIL illegal_first: err=%b err_idx=%0d done=%b count=%0d, want 1 3 1 6",
                     err_a, err_idx_a, done_a, count_a);
        end
        pulse_start();
        checks++;
        if (err_a !== 1'b0 || err_idx_a !== 9'd0) begin
            errors++;
            $display("FAIL err_clear_on_start: err=%b err_idx=%0d, want 0 0", err_a, err_idx_a);
        end
        send(0, 4'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 32'hFE20AE23, 0);
        send(0, 4'd1, 3'd1, 7'h20, 5'd5, 5'd5, 5'd0, 32'd3, 1'b0, NOP, 1);
        send(0, 4'd8, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, NOP, 2);
        drain(0);
        checks++;
        if (err_a !== 1'b1 || err_idx_a !== 9'd1 || done_a !== 1'b1 || ovf_a !== 1'b0 || count_a !== 9'd3) begin
            errors++;
            $display("FAIL illegal_last: err=%b err_idx=%0d done=%b ovf=%b count=%0d, want 1 1 1 0 3",
                     err_a, err_idx_a, done_a, ovf_a, count_a);
        end
    endtask

    task automatic test_back_to_back();
        int acc [4];
        pulse_start();
        send(0, 4'd2, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'd8, 1'b0, 32'h00812203, 0);
        acc[0] = last_acc;
        send(0, 4'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 32'hFE20AE23, 1);
        acc[1] = last_acc;
        send(0, 4'd4, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7, 2);
        acc[2] = last_acc;
        send(0, 4'd7, 3'd0, 7'd0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1, 32'h00008067, 3);
        acc[3] = last_acc;
        drain(0);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 1) begin
                errors++;
                $display("FAIL back_to_back_gap[%0d]: %0d cycles between accepts, want 1", i, acc[i] - acc[i-1]);
            end
        end
        checks++;
        if (done_a !== 1'b1 || count_a !== 9'd4 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_done: done=%b count=%0d err=%b, want 1 4 0", done_a, count_a, err_a);
        end
    endtask

    task automatic test_overflow();
        en_a = 1'b0;
        en_b = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++)
            send(1, 4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, i);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready_b !== 1'b0) begin
                errors++;
                $display("FAIL ovf_ready[%0d]: in_ready=%b, want 0", i, in_ready_b);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ovf_b !== 1'b1 || done_b !== 1'b1 || count_b !== 3'd4 || busy_b !== 1'b0 || qb.size() != 0) begin
            errors++;
            $display("FAIL ovf_status: ovf=%b done=%b count=%0d busy=%b pending=%0d, want 1 1 4 0 0",
                     ovf_b, done_b, count_b, busy_b, qb.size());
        end
        repeat (3) @(posedge clk);
        #1;
        en_b = 1'b0;
        en_a = 1'b1;
    endtask

    task automatic test_rst_midflight();
        pulse_start();
        in_kind = 4'd1; in_funct3 = 3'd0; in_funct7 = 7'd0; in_rd = 5'd1;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd5; in_last = 1'b0;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, count_a, busy_a, done_a, err_a, err_idx_a, ovf_a} !== '0) begin
            errors++;
            $display("FAIL rst_override: we=%b addr=%h data=%h count=%0d busy=%b rdy=%b, want all 0",
                     mem_we_a, mem_addr_a, mem_wdata_a, count_a, busy_a, in_ready_a);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            @(negedge clk);
            checks++;
            if (mem_we_a !== 1'b0 || in_ready_a !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_write[%0d]: mem_we=%b in_ready=%b, want 0 0", i, mem_we_a, in_ready_a);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_r_shift();
        test_branch_jal();
        test_illegal();
        test_back_to_back();
        test_overflow();
        test_rst_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the control unit's decode: accepts field-level micro-op descriptions over a valid/ready stream and packs them into RV32I instruction words.
- Writes each word sequentially into instruction memory through a write port, checking immediate ranges per format.
- Used by the test/boot infrastructure to build programs in instruction memory without external hex files.

Parameters:
- ADDR_WIDTH, 10: byte-address width of the instruction memory write port; capacity = 2^ADDR_WIDTH/4 words.
- NOP_WORD, 32'h00000013: word written in place of an illegal request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; clears pointer/flags, enters LOAD
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept this cycle
- in_kind  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR, 8 BRANCH; 9-15 illegal
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 (R; I-ALU shifts use it as imm[11:5])
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed byte immediate (LUI/AUIPC: full value, bits[11:0] must be 0)
- in_last  in  1  marks final request of the program
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  word-aligned byte address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_WIDTH-1  words written since start
- busy  out  1  state is LOAD or FLUSH
- done  out  1  level, state DONE
- err  out  1  sticky, any illegal request
- err_idx  out  ADDR_WIDTH-1  word index of first illegal request
- ovf  out  1  memory filled before in_last

Behaviour:
- Reset: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, done=0, err=0, err_idx=0, ovf=0, in_ready=0. rst overrides start and any in-flight write; a pending word is discarded.
- States:
  - IDLE: on start, go to LOAD.
  - LOAD: a request is accepted when in_valid && in_ready.
  - FLUSH: entered after accepting in_last or the last-capacity word; lasts exactly 1 cycle while that word is written, then go to DONE.
  - DONE: holds until start, which returns to LOAD with count/err/err_idx/ovf cleared.
  - start in LOAD restarts at address 0 and discards a pending word.
- in_ready = (state==LOAD) && !(pointer==capacity-1 && a write is pending).
- Latency: a request accepted at edge N appears with mem_we=1 in cycle N+1, holding mem_addr=4*pointer and the encoded word. The pointer then increments.
- Throughput: 1 word/cycle.
- mem_we is high for exactly one cycle per accepted request. Held in_valid with in_ready low: no accept and no write.
- Encoding uses standard RV32I opcodes: 33, 13, 03, 23, 37, 17, 6F, 67, 63 hex. in_funct7 goes to [31:25] for R-type and for I-ALU funct3 001/101.
- Legality, checked on in_imm:
  - I-ALU/LOAD/JALR: -2048..2047.
  - Shifts: 0..31, with in_funct7 equal to 00 (funct3 001/101) or 20 (funct3 101 only).
  - STORE: -2048..2047.
  - BRANCH: even, -4096..4094; funct3 must not be 010 or 011.
  - JAL: even, -1048576..1048574.
  - LUI/AUIPC: imm[11:0]==0.
  - R-type: funct7 00 is legal for all funct3; funct7 20 is legal only with funct3 000/101.
- Illegal request: write NOP_WORD at the pointer. Set err. If err was clear, set err_idx = pointer. The pointer still advances.
- Capacity: if the word written at index capacity-1 did not carry in_last, set ovf=1 and go to DONE. Words past capacity are never written, and the pointer never wraps.
- Simultaneous in_last with an illegal request: write NOP, set err, and finish normally.

Test Plan:
- start; addi x1,x0,5 (kind1 f3 0 rd1 imm5) -> mem_we at addr 0, wdata 32'h00500093, 1 cycle after accept.
- sub x3,x1,x2 (kind0 f7 20) then srai x5,x5,3 (kind1 f3 5 f7 20 imm3, in_last) -> addr 0 32'h402081B3, addr 4 32'h4032D293; then done=1, count=2.
- beq x1,x2,-8 (kind8) -> 32'hFE208CE3; jal x1,2048 (kind6 rd1) -> 32'h001000EF.
- Illegal addi with imm 4096 at index 3 -> wdata 32'h00000013, err=1, err_idx=3; next request written at addr 16.
- ADDR_WIDTH=4, 5 back-to-back requests without in_last -> 4 writes (addr 0..12), ovf=1, done=1, 5th request never accepted.
- rst asserted the cycle after an accept -> no mem_we that cycle, all outputs return to reset values; in_valid toggling with in_ready low -> no writes.
